negate_serial: RTL and testbench



---
 rtl/alu_pkg.sv | 15 +
 rtl/negate_chunk.sv | 26 ++
 rtl/negate_serial.sv | 156 +++++++++++++++
 tb/tb_negate_serial.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation mode encodings and the serial negator state encoding.
// No ports; imported by negate_serial and its bench.
package alu_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/negate_chunk.sv
// One CHUNK-wide slice of the serial negator: optional invert plus carry-in add.
// Ports:
//   x    - operand slice
//   inv  - invert x before the add
//   cin  - carry in from the previous slice
//   y    - slice result
//   cout - carry out to the next slice
module negate_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic             inv,
  input  logic             cin,
  output logic [CHUNK-1:0] y,
  output logic             cout
);

  localparam int unsigned SUMW = CHUNK + 1;

  logic [CHUNK:0] w_sum;

  assign w_sum = {1'b0, (inv ? ~x : x)} + SUMW'(cin);
  assign y     = w_sum[CHUNK-1:0];
  assign cout  = w_sum[CHUNK];

endmodule

// File: rtl/negate_serial.sv
// Multi-cycle two's-complement pass / negate / abs unit, CHUNK bits per cycle,
// least-significant chunk first, with a registered carry between chunks.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   start     - request, accepted in IDLE or DONE
//   mode      - 00 pass, 01 negate, 10 abs, 11 pass
//   a         - signed operand, sampled with start
//   busy      - operation in progress
//   done      - one-cycle completion pulse
//   result    - signed result, held until the next completion
//   overflow  - result not representable (negating the most-negative value)
module negate_serial
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(1) << (WIDTH - 1);

  generate
    if (CHUNK < 1) begin : g_bad_chunk
      $error("negate_serial: CHUNK must be at least 1");
    end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
      $error("negate_serial: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_op;
  logic [WIDTH-1:0] r_shadow;
  logic             r_inv;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_overflow;

  logic             w_inv_in;
  logic [CHUNK-1:0] w_chunk_y;
  logic             w_chunk_cout;
  logic [WIDTH-1:0] w_shadow_nxt;

  // Invert flag is decided once, from the operand sign at acceptance.
  assign w_inv_in = (mode == MODE_NEG) || ((mode == MODE_ABS) && a[WIDTH-1]);

  negate_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x    (r_op[CHUNK-1:0]),
    .inv  (r_inv),
    .cin  (r_carry),
    .y    (w_chunk_y),
    .cout (w_chunk_cout)
  );

  // Shadow fills from the top; after NCHUNK shifts the first chunk sits at bit 0.
  assign w_shadow_nxt = (r_shadow >> CHUNK) | (WIDTH'(w_chunk_y) << (WIDTH - CHUNK));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and acceptance decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_last = (r_idx == IDXW'(NCHUNK - 1));
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= '0;
      r_shadow   <= '0;
      r_inv      <= 1'b0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_op     <= a;
        r_inv    <= w_inv_in;
        r_carry  <= w_inv_in;
        r_idx    <= '0;
        r_shadow <= '0;
        r_busy   <= 1'b1;
      end else if (r_state == S_RUN) begin
        r_op     <= r_op >> CHUNK;
        r_carry  <= w_chunk_cout;
        r_shadow <= w_shadow_nxt;
        r_idx    <= r_idx + IDXW'(1);
        if (w_last) begin
          // Only -MIN wraps back to MIN, so MIN with inv set means overflow.
          r_result   <= w_shadow_nxt;
          r_overflow <= r_inv && (w_shadow_nxt == MOST_NEG);
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_negate_serial.sv
// Scoreboard bench for negate_serial: directed vectors on the default 32/8 instance,
// plus random operations on four other WIDTH/CHUNK configurations.
module tb_negate_serial;
  import alu_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned C = 8;
  localparam int unsigned N = W / C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit sw_done [4];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp_v, cyc);
    end
  endtask

  // ---------------- main 32/8 instance ----------------
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] a = '0;
  logic         busy, done, overflow;
  logic [W-1:0] result;

  negate_serial #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a),
    .busy(busy), .done(done), .result(result), .overflow(overflow)
  );

  logic [W-1:0] q_res [$];
  logic         q_ovf [$];
  int           q_edge [$];
  logic [W-1:0] hold_res = '0;
  logic         hold_ovf = 1'b0;
  int           busy_cnt = 0;

  // Monitor: pops on done, otherwise checks outputs are held.
  always @(negedge clk) begin
    if (rst) begin
      hold_res = '0;
      hold_ovf = 1'b0;
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (q_res.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got result=%h exp no done (cycle %0d)", result, cyc);
        end else begin
          logic [W-1:0] er;
          logic         eo;
          int           ee;
          er = q_res.pop_front();
          eo = q_ovf.pop_front();
          ee = q_edge.pop_front();
          chk("result", 64'(result), 64'(er));
          chk("overflow", 64'(overflow), 64'(eo));
          chk("latency", 64'(cyc), 64'(ee));
          chk("busy_cycles", 64'(busy_cnt), 64'(N));
          hold_res = er;
          hold_ovf = eo;
        end
        busy_cnt = 0;
      end else begin
        chk("result_held", 64'(result), 64'(hold_res));
        chk("overflow_held", 64'(overflow), 64'(hold_ovf));
      end
    end
  end

  // Called at a negedge; waits for busy=0 (IDLE or DONE) and pulses start for one edge.
  task automatic issue(input logic [1:0] m, input logic [W-1:0] x,
                       input logic [W-1:0] er, input logic eo, input bit expect_done);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout got busy=1 exp busy=0");
    end
    mode  = m;
    a     = x;
    start = 1'b1;
    if (expect_done) begin
      q_res.push_back(er);
      q_ovf.push_back(eo);
      q_edge.push_back(cyc + 1 + int'(N));
    end
    @(negedge clk);
    start = 1'b0;
    a     = ~x;
    mode  = ~m;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_res.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got pending=%0d exp 0", q_res.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_result", 64'(result), 64'(0));
    chk("reset_overflow", 64'(overflow), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    issue(MODE_NEG, 32'd5, 32'hFFFF_FFFB, 1'b0, 1'b1);
    drain();
    issue(MODE_NEG, 32'h0000_0100, 32'hFFFF_FF00, 1'b0, 1'b1);
    issue(MODE_NEG, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
    drain();
    issue(MODE_ABS, 32'hFFFF_FF85, 32'h0000_007B, 1'b0, 1'b1);
    issue(MODE_ABS, 32'h0000_007B, 32'h0000_007B, 1'b0, 1'b1);
    drain();
    issue(MODE_NEG,  32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
    issue(MODE_ABS,  32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
    issue(MODE_PASS, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
    drain();
    issue(2'b11,    32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1);
    issue(MODE_NEG, 32'h1234_5678, 32'hEDCB_A988, 1'b0, 1'b1);
    drain();

    // Start pulsed mid-run must be ignored.
    issue(MODE_NEG, 32'd7, 32'hFFFF_FFF9, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b1;
    a     = 32'd1;
    mode  = MODE_PASS;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Back-to-back: second start lands in the DONE cycle.
    issue(MODE_PASS, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1);
    issue(MODE_ABS,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    drain();

    // Reset on the chunk-2 edge aborts with no done.
    issue(MODE_NEG, 32'h0000_0055, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_result", 64'(result), 64'(0));
    chk("abort_overflow", 64'(overflow), 64'(0));
    rst = 1'b0;
    repeat (N + 3) @(negedge clk);

    issue(MODE_NEG, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    drain();

    n = 0;
    while (!(sw_done[0] && sw_done[1] && sw_done[2] && sw_done[3]) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      errors++;
      $display("FAIL sweep_timeout got unfinished exp all finished");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- parameter sweep ----------------
  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int unsigned SW = (g == 0) ? 16 : (g == 1) ? 32 : (g == 2) ? 64 : 8;
    localparam int unsigned SC = (g == 0) ? 4  : (g == 1) ? 32 : (g == 2) ? 8  : 1;
    localparam int unsigned SN = SW / SC;
    localparam logic [SW-1:0] SMIN = SW'(1) << (SW - 1);

    logic          s_rst = 1'b1;
    logic          s_start = 1'b0;
    logic [1:0]    s_mode = 2'b00;
    logic [SW-1:0] s_a = '0;
    logic          s_busy, s_done, s_ovf;
    logic [SW-1:0] s_res;

    negate_serial #(.WIDTH(SW), .CHUNK(SC)) u_dut (
      .clk(clk), .rst(s_rst), .start(s_start), .mode(s_mode), .a(s_a),
      .busy(s_busy), .done(s_done), .result(s_res), .overflow(s_ovf)
    );

    logic [SW-1:0] sq_res [$];
    logic          sq_ovf [$];
    int            sq_edge [$];

    always @(negedge clk) begin
      if (!s_rst && s_done) begin
        if (sq_res.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sw%0d_unexpected_done got result=%h exp no done", g, s_res);
        end else begin
          logic [SW-1:0] er;
          logic          eo;
          int            ee;
          er = sq_res.pop_front();
          eo = sq_ovf.pop_front();
          ee = sq_edge.pop_front();
          chk($sformatf("sw%0d_result", g), 64'(s_res), 64'(er));
          chk($sformatf("sw%0d_overflow", g), 64'(s_ovf), 64'(eo));
          chk($sformatf("sw%0d_latency", g), 64'(cyc), 64'(ee));
        end
      end
    end

    initial begin
      logic [SW-1:0] x;
      logic [1:0]    m;
      logic          inv;
      int            n;
      repeat (2) @(negedge clk);
      s_rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 24; i++) begin
        m = 2'($urandom_range(0, 3));
        x = SW'({$urandom, $urandom});
        if (i % 8 == 1) x = SMIN;
        if (i % 8 == 5) x = '0;
        if (i % 8 == 3) x = '1;
        inv = (m == MODE_NEG) || ((m == MODE_ABS) && x[SW-1]);
        n = 0;
        while (s_busy && n < 1000) begin
          @(negedge clk);
          n++;
        end
        if (n >= 1000) begin
          checks++;
          errors++;
          $display("FAIL sw%0d_issue_timeout got busy=1 exp busy=0", g);
        end
        s_mode  = m;
        s_a     = x;
        s_start = 1'b1;
        sq_res.push_back(inv ? SW'(0 - x) : x);
        sq_ovf.push_back(inv && (x == SMIN));
        sq_edge.push_back(cyc + 1 + int'(SN));
        @(negedge clk);
        s_start = 1'b0;
        s_a     = ~x;
        if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      n = 0;
      while ((sq_res.size() != 0 || s_busy) && n < 1000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 1000) begin
        checks++;
        errors++;
        $display("FAIL sw%0d_drain_timeout got pending=%0d exp 0", g, sq_res.size());
      end
      sw_done[g] = 1'b1;
    end
  end

endmodule
